// File: rtl/pcie_c4_1x_rst_pkg.sv
// pcie_c4_1x_rst_pkg
//   Shared definitions for the 1x chaining-DMA application reset sequencer:
//   the sequencer state encoding and the shortened simulation timing values
//   that replace GAP/TIMEOUT when test_sim is asserted.
package pcie_c4_1x_rst_pkg;

  // Sequencer states, encoded as fixed 2-bit values so waveforms and any
  // legacy tooling that decodes the state register see stable numbers.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } seq_state_t;

  // Simulation-mode replacements for the release gap and the drain timeout.
  localparam int SIM_GAP     = 2;
  localparam int SIM_TIMEOUT = 32;

endpackage

// File: rtl/pcie_c4_1x_rst_sync.sv
// pcie_c4_1x_rst_sync
//   Two-flop synchronizer that brings the HIP app_rstn into the pld_clk
//   domain. Clearing under rst forces the synchronized output low, so the
//   sequencer always treats a block reset as "application in reset".
// Ports:
//   clk  in  sampling clock
//   rst  in  asynchronous active-high clear
//   d    in  asynchronous input
//   q    out synchronized output (two clk edges of latency)
module pcie_c4_1x_rst_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift; the first stage may go metastable and is given a
  // full cycle to resolve before anything downstream looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pcie_c4_1x_app_rst_seq.sv
// pcie_c4_1x_app_rst_seq
//   Application-side reset sequencer. Releases NDOM application reset domains
//   one at a time (index order, GAP cycles apart) after app_rstn rises, and on
//   app_rstn falling asks every released domain to quiesce, waits for all of
//   them to acknowledge (or for TIMEOUT cycles), then resets them together.
// Ports:
//   pld_clk      in   application clock
//   rst          in   asynchronous active-high block reset
//   app_rstn     in   active-low application reset from the HIP (async)
//   test_sim     in   selects short simulation timing (GAP=2, TIMEOUT=32)
//   quiesce_req  out  per-domain request to stop issuing traffic
//   quiesce_ack  in   per-domain idle indication (level)
//   dom_rstn     out  per-domain active-low reset
//   rst_busy     out  high whenever the sequencer is not in RUN
//   timed_out    out  sticky: last drain ended by timeout
module pcie_c4_1x_app_rst_seq
  import pcie_c4_1x_rst_pkg::*;
#(
  parameter int NDOM    = 4,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic            pld_clk,
  input  logic            rst,
  input  logic            app_rstn,
  input  logic            test_sim,
  output logic [NDOM-1:0] quiesce_req,
  input  logic [NDOM-1:0] quiesce_ack,
  output logic [NDOM-1:0] dom_rstn,
  output logic            rst_busy,
  output logic            timed_out
);

  // The counter must cover the longest of the normal and simulation periods.
  localparam int MAX_GT  = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int CNT_MAX = (MAX_GT > SIM_TIMEOUT) ? MAX_GT : SIM_TIMEOUT;
  localparam int CNTW    = $clog2(CNT_MAX);
  localparam int IDXW    = (NDOM > 1) ? $clog2(NDOM) : 1;

  localparam logic [CNTW-1:0] GAP_LAST     = CNTW'(GAP - 1);
  localparam logic [CNTW-1:0] TO_LAST      = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] SIM_GAP_LAST = CNTW'(SIM_GAP - 1);
  localparam logic [CNTW-1:0] SIM_TO_LAST  = CNTW'(SIM_TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST     = IDXW'(NDOM - 1);
  localparam logic [NDOM-1:0] DOM_ONE      = NDOM'(1);

  seq_state_t      state;
  logic [CNTW-1:0] cnt;
  logic [IDXW-1:0] idx;
  logic            app_rstn_s;
  logic            done_r;
  logic [CNTW-1:0] gap_last;
  logic [CNTW-1:0] to_last;
  logic            all_done;

  pcie_c4_1x_rst_sync u_sync (
    .clk (pld_clk),
    .rst (rst),
    .d   (app_rstn),
    .q   (app_rstn_s)
  );

  // Terminal counts for the current timing mode. A domain that was never
  // asked to quiesce counts as done, so its ack line is don't-care.
  always_comb begin
    gap_last = test_sim ? SIM_GAP_LAST : GAP_LAST;
    to_last  = test_sim ? SIM_TO_LAST  : TO_LAST;
    all_done = &(quiesce_ack | ~quiesce_req);
  end

  // Main sequencer. done_r registers the drain-complete condition, so the
  // domains are reset one edge after the edge that samples all acks; it is
  // cleared on DRAIN entry so a stale value can never end a fresh drain.
  always_ff @(posedge pld_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      dom_rstn    <= '0;
      quiesce_req <= '0;
      rst_busy    <= 1'b1;
      timed_out   <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      done_r      <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (app_rstn_s) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        ST_RELEASE: begin
          if (!app_rstn_s) begin
            // Abort the release; only the domains already out of reset drain.
            state       <= ST_DRAIN;
            quiesce_req <= dom_rstn;
            cnt         <= '0;
            timed_out   <= 1'b0;
            done_r      <= 1'b0;
          end else if (cnt == gap_last) begin
            dom_rstn <= dom_rstn | (DOM_ONE << idx);
            cnt      <= '0;
            if (idx == IDX_LAST) begin
              state    <= ST_RUN;
              rst_busy <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!app_rstn_s) begin
            state       <= ST_DRAIN;
            quiesce_req <= dom_rstn;
            cnt         <= '0;
            timed_out   <= 1'b0;
            done_r      <= 1'b0;
            rst_busy    <= 1'b1;
          end
        end

        ST_DRAIN: begin
          // app_rstn_s is deliberately ignored here: a drain always finishes
          // and HOLD then decides whether to start a fresh release.
          done_r <= all_done;
          if (done_r || (cnt == to_last)) begin
            dom_rstn    <= '0;
            quiesce_req <= '0;
            timed_out   <= ~done_r;
            done_r      <= 1'b0;
            state       <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_c4_1x_app_rst_seq.sv
// tb_pcie_c4_1x_app_rst_seq
//   Directed bench for the application reset sequencer (NDOM=4, GAP=16,
//   TIMEOUT=1024). Edge numbers below count the first pld_clk edge that
//   samples a new app_rstn level as edge 1.
module tb_pcie_c4_1x_app_rst_seq;

  logic       pld_clk;
  logic       rst;
  logic       app_rstn;
  logic       test_sim;
  logic [3:0] quiesce_req;
  logic [3:0] quiesce_ack;
  logic [3:0] dom_rstn;
  logic       rst_busy;
  logic       timed_out;

  int checkCount;
  int failCount;

  pcie_c4_1x_app_rst_seq #(
    .NDOM    (4),
    .GAP     (16),
    .TIMEOUT (1024)
  ) dut (
    .pld_clk     (pld_clk),
    .rst         (rst),
    .app_rstn    (app_rstn),
    .test_sim    (test_sim),
    .quiesce_req (quiesce_req),
    .quiesce_ack (quiesce_ack),
    .dom_rstn    (dom_rstn),
    .rst_busy    (rst_busy),
    .timed_out   (timed_out)
  );

  initial pld_clk = 1'b0;
  always #5 pld_clk = ~pld_clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the sequencer's inputs; called just after a clock edge.
  task automatic applyStimulus(input logic rstn, input logic [3:0] ack, input logic sim);
    app_rstn    = rstn;
    quiesce_ack = ack;
    test_sim    = sim;
  endtask

  // Advance n edges and land 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge pld_clk);
      #1;
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Reset values
    #12;
    checkOutput("rst_dom", 32'(dom_rstn), 32'h0);
    checkOutput("rst_req", 32'(quiesce_req), 32'h0);
    checkOutput("rst_busy", 32'(rst_busy), 32'h1);
    checkOutput("rst_tmo", 32'(timed_out), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(3);
    checkOutput("hold_dom", 32'(dom_rstn), 32'h0);

    // Power-up release with normal timing
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick(18);
    checkOutput("rel_e18", 32'(dom_rstn), 32'h0);
    tick(1);
    checkOutput("rel_e19", 32'(dom_rstn), 32'h1);
    tick(16);
    checkOutput("rel_e35", 32'(dom_rstn), 32'h3);
    tick(16);
    checkOutput("rel_e51", 32'(dom_rstn), 32'h7);
    tick(15);
    checkOutput("busy_e66", 32'(rst_busy), 32'h1);
    tick(1);
    checkOutput("rel_e67", 32'(dom_rstn), 32'hF);
    checkOutput("busy_e67", 32'(rst_busy), 32'h0);
    tick(2);

    // Drain with acks 5 cycles after quiesce_req
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(2);
    checkOutput("drn_req_e2", 32'(quiesce_req), 32'h0);
    tick(1);
    checkOutput("drn_req_e3", 32'(quiesce_req), 32'hF);
    checkOutput("drn_busy", 32'(rst_busy), 32'h1);
    tick(5);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    tick(1);
    checkOutput("drn_dom_smp", 32'(dom_rstn), 32'hF);
    tick(1);
    checkOutput("drn_dom_done", 32'(dom_rstn), 32'h0);
    checkOutput("drn_req_done", 32'(quiesce_req), 32'h0);
    checkOutput("drn_tmo", 32'(timed_out), 32'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    tick(3);

    // Simulation timing release, then a drain that times out
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick(4);
    checkOutput("sim_e4", 32'(dom_rstn), 32'h0);
    tick(1);
    checkOutput("sim_e5", 32'(dom_rstn), 32'h1);
    tick(6);
    checkOutput("sim_e11", 32'(dom_rstn), 32'hF);
    checkOutput("sim_busy", 32'(rst_busy), 32'h0);
    tick(2);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick(34);
    checkOutput("tmo_e34_dom", 32'(dom_rstn), 32'hF);
    checkOutput("tmo_e34_flag", 32'(timed_out), 32'h0);
    tick(1);
    checkOutput("tmo_e35_dom", 32'(dom_rstn), 32'h0);
    checkOutput("tmo_e35_flag", 32'(timed_out), 32'h1);
    checkOutput("tmo_e35_req", 32'(quiesce_req), 32'h0);
    tick(3);

    // Partial release 0011, drain with mid-drain re-raise of app_rstn
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick(5);
    checkOutput("part_e5", 32'(dom_rstn), 32'h1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick(2);
    checkOutput("part_f2_dom", 32'(dom_rstn), 32'h3);
    checkOutput("part_f2_tmo", 32'(timed_out), 32'h1);
    tick(1);
    checkOutput("part_f3_req", 32'(quiesce_req), 32'h3);
    checkOutput("part_f3_tmo", 32'(timed_out), 32'h0);
    applyStimulus(1'b0, 4'b1100, 1'b1);
    tick(3);
    checkOutput("part_f6_dom", 32'(dom_rstn), 32'h3);
    applyStimulus(1'b1, 4'b1100, 1'b1);
    tick(4);
    checkOutput("part_f10_dom", 32'(dom_rstn), 32'h3);
    checkOutput("part_f10_req", 32'(quiesce_req), 32'h3);
    applyStimulus(1'b1, 4'b0011, 1'b1);
    tick(1);
    checkOutput("part_f11_dom", 32'(dom_rstn), 32'h3);
    tick(1);
    checkOutput("part_f12_dom", 32'(dom_rstn), 32'h0);
    checkOutput("part_f12_req", 32'(quiesce_req), 32'h0);
    checkOutput("part_f12_tmo", 32'(timed_out), 32'h0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick(2);
    checkOutput("rerel_f14", 32'(dom_rstn), 32'h0);
    tick(1);
    checkOutput("rerel_f15", 32'(dom_rstn), 32'h1);
    tick(6);
    checkOutput("rerel_f21", 32'(dom_rstn), 32'hF);
    checkOutput("rerel_busy", 32'(rst_busy), 32'h0);

    // Quick drain, then async rst in the middle of RELEASE
    applyStimulus(1'b0, 4'b1111, 1'b1);
    tick(5);
    checkOutput("qd_f5_dom", 32'(dom_rstn), 32'h0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick(7);
    checkOutput("ar_e7_dom", 32'(dom_rstn), 32'h3);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_dom", 32'(dom_rstn), 32'h0);
    checkOutput("ar_req", 32'(quiesce_req), 32'h0);
    checkOutput("ar_busy", 32'(rst_busy), 32'h1);
    checkOutput("ar_tmo", 32'(timed_out), 32'h0);
    tick(2);
    checkOutput("ar_hold_dom", 32'(dom_rstn), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
